// File: rtl/disp_pkg.sv
// Shared constants for the IO display path: active-low segment codes,
// converter state encoding and a digit decoder.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned DIGITS_W   = $clog2(NUM_DIGITS);

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic [0:0] {IDLE, CONV} conv_state_e;

    // Non-decimal codes cannot come out of the converter; blank them anyway.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// A load arriving while a conversion runs is parked in a single pending slot
// (newest wins) and started as soon as the current conversion completes.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned BCD_W = 4 * DIGITS;

    conv_state_e        state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic [DATA_W-1:0]  pend_data_q, pend_data_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_step;
    logic [DATA_W-1:0]  bin_step;
    logic               last_step;

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_step  = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_step  = {bin_q[DATA_W-2:0], 1'b0};
        last_step = (cnt_q == CNT_W'(DATA_W - 1));
    end

    // Next-state logic: start, step, complete, and pending-load bookkeeping.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        pend_data_d = pend_data_q;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d     = data_in;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = CONV;
                end else if (pending_q) begin
                    // Only reachable when a load landed on a completion edge.
                    bin_d     = pend_data_q;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                bin_d = bin_step;
                bcd_d = bcd_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (load) begin
                    pend_data_d = data_in;
                    pending_d   = 1'b1;
                end
                if (last_step) begin
                    done = 1'b1;
                    if (pending_q) begin
                        bin_d     = pend_data_q;
                        bcd_d     = '0;
                        cnt_d     = '0;
                        pending_d = load;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign busy = (state_q == CONV);
    // Valid only while done is high: the result of the final step.
    assign bcd  = bcd_step;

endmodule

// File: rtl/io_display_driver.sv
// Shows the CPU IO output word in decimal on a multiplexed common-anode
// 7-segment display. Optional build macro: LEADING_ZERO_BLANK_EN blanks digits
// above the most-significant nonzero digit (ones digit always shown).
module io_display_driver
    import disp_pkg::*;
#(
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned DIGITS      = NUM_DIGITS,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS == NUM_DIGITS) ? DIGITS_W :
                                    ((DIGITS > 1) ? $clog2(DIGITS) : 1);

    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [4*DIGITS-1:0] disp_q;
    logic [REF_W-1:0]    ref_q;
    logic [IDX_W-1:0]    idx_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic [3:0]          cur_digit;
    logic                cur_blank;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

    // Display register: updated only when a conversion completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (done) begin
            disp_q <= bcd;
        end
    end

    // Free-running refresh divider and digit-slot index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_q <= '0;
            idx_q <= '0;
        end else if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            ref_q <= ref_q + REF_W'(1);
        end
    end

    // Select the digit for the current slot and decide whether to blank it.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = disp_q[4*i +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead      = 1'b1;
            cur_blank = 1'b0;
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                if (disp_q[4*i +: 4] != 4'd0) begin
                    lead = 1'b0;
                end
                if (lead && (idx_q == IDX_W'(i))) begin
                    cur_blank = 1'b1;
                end
            end
        end
`else
        cur_blank = 1'b0;
`endif
    end

    // Registered scan outputs: selected anode low, matching segment pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            an_q  <= ~(DIGITS'(1) << idx_q);
            seg_q <= cur_blank ? SEG_BLANK : seg_decode(cur_digit);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_io_display_driver.sv
// Directed bench for io_display_driver with a fast refresh divider (4).
module tb_io_display_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [13:0] data_in;
    logic        busy;
    logic [6:0]  seg;
    logic [4:0]  an;

    int checks = 0;
    int errors = 0;

    io_display_driver #(
        .DATA_W      (14),
        .DIGITS      (5),
        .REFRESH_DIV (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data_in (data_in),
        .busy    (busy),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        logic [6:0] t [0:9];
        t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
        t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
        t[8] = 7'b0000000; t[9] = 7'b0010000;
        return (d <= 4'd9) ? t[d] : 7'b1111111;
    endfunction

    // Expected pattern for slot s of a 5-digit BCD value.
    function automatic logic [6:0] slot_seg(input logic [19:0] val, input int s);
        logic [3:0] d;
        int msd;
        d   = val[4*s +: 4];
        msd = 0;
        for (int i = 0; i < 5; i++) if (val[4*i +: 4] != 4'd0) msd = i;
`ifdef LEADING_ZERO_BLANK_EN
        if (s > msd) return 7'b1111111;
`endif
        return exp_seg(d);
    endfunction

    task automatic pulse_load(input logic [13:0] v);
        load    = 1'b1;
        data_in = v;
        tick();
        load    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $error("FAIL %s: busy stuck, observed %0b expected 0", tag, busy);
        end
    endtask

    // Walk every slot once and compare its segments.
    task automatic check_disp(input string tag, input logic [19:0] val);
        for (int s = 0; s < 5; s++) begin
            int n = 0;
            logic [4:0] want_an;
            want_an = ~(5'b00001 << s);
            while (an !== want_an && n < 40) begin
                tick();
                n++;
            end
            if (n >= 40) begin
                checks++;
                errors++;
                $error("FAIL %s slot %0d: an observed %b expected %b", tag, s, an, want_an);
            end else begin
                chk($sformatf("%s slot%0d", tag, s), 32'(seg), 32'(slot_seg(val, s)));
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = '0;

        // Reset: blank segments, all anodes off
        repeat (3) tick();
        chk("rst seg", 32'(seg), 32'h7f);
        chk("rst an", 32'(an), 32'h1f);
        chk("rst busy", 32'(busy), 32'h0);

        // Scan order after release: 4 cycles per slot, zeros shown
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            logic [4:0] ea;
            tick();
            ea = ~(5'b00001 << ((j / 4) % 5));
            chk($sformatf("scan an %0d", j), 32'(an), 32'(ea));
            if (j % 4 == 0) chk($sformatf("scan seg %0d", j), 32'(seg), 32'(7'b1000000));
        end

        // 12345: busy through edge k+13, low after k+14
        pulse_load(14'd12345);
        chk("busy k", 32'(busy), 32'h1);
        for (int j = 1; j <= 13; j++) begin
            tick();
            chk($sformatf("busy k+%0d", j), 32'(busy), 32'h1);
        end
        tick();
        chk("busy k+14", 32'(busy), 32'h0);
        check_disp("d12345", 20'h12345);

        // Maximum value
        pulse_load(14'd16383);
        wait_idle("w16383");
        check_disp("d16383", 20'h16383);

        // Zero
        pulse_load(14'd0);
        wait_idle("w0");
        check_disp("d0", 20'h00000);

        // 305 (exercises leading blanking when enabled)
        pulse_load(14'd305);
        wait_idle("w305");
        check_disp("d305", 20'h00305);

        // Back-to-back loads: 100 at k, 42 at k+5, 7 at k+9; 42 is overwritten
        pulse_load(14'd100);
        repeat (4) tick();
        pulse_load(14'd42);
        repeat (3) tick();
        pulse_load(14'd7);
        repeat (4) tick();
        tick();
        chk("pend busy k+14", 32'(busy), 32'h1);
        for (int j = 15; j <= 28; j++) begin
            tick();
            for (int s = 0; s < 5; s++) begin
                logic [4:0] wa;
                wa = ~(5'b00001 << s);
                if (an === wa) chk($sformatf("pend100 k+%0d", j), 32'(seg), 32'(slot_seg(20'h00100, s)));
            end
            if (j == 27) chk("pend busy k+27", 32'(busy), 32'h1);
        end
        chk("pend busy k+28", 32'(busy), 32'h0);
        check_disp("d7", 20'h00007);

        // Reset mid-conversion: aborts, display stays cleared
        pulse_load(14'd999);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("abort busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("abort busy late", 32'(busy), 32'h0);
        check_disp("abort", 20'h00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $error("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
